// File: rtl/march_pkg.sv
// Shared types and the March C- element table for the BIST controller.
package march_pkg;

  localparam int NUM_ELEM = 6;

  typedef logic [2:0] elem_idx_t;

  localparam elem_idx_t LAST_ELEM = elem_idx_t'(NUM_ELEM - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_OP_R  = 3'd2,
    ST_OP_W  = 3'd3,
    ST_DRAIN = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  typedef struct packed {
    logic dir_up;
    logic has_read;
    logic has_write;
    logic read_bg;
    logic write_bg;
  } elem_t;

  // any(w0) up(r0,w1) up(r1,w0) dn(r0,w1) dn(r1,w0) any(r0); "any" sweeps up
  localparam elem_t ELEM_0 = '{dir_up: 1'b1, has_read: 1'b0, has_write: 1'b1, read_bg: 1'b0, write_bg: 1'b0};
  localparam elem_t ELEM_1 = '{dir_up: 1'b1, has_read: 1'b1, has_write: 1'b1, read_bg: 1'b0, write_bg: 1'b1};
  localparam elem_t ELEM_2 = '{dir_up: 1'b1, has_read: 1'b1, has_write: 1'b1, read_bg: 1'b1, write_bg: 1'b0};
  localparam elem_t ELEM_3 = '{dir_up: 1'b0, has_read: 1'b1, has_write: 1'b1, read_bg: 1'b0, write_bg: 1'b1};
  localparam elem_t ELEM_4 = '{dir_up: 1'b0, has_read: 1'b1, has_write: 1'b1, read_bg: 1'b1, write_bg: 1'b0};
  localparam elem_t ELEM_5 = '{dir_up: 1'b1, has_read: 1'b1, has_write: 1'b0, read_bg: 1'b0, write_bg: 1'b0};
  localparam elem_t ELEM_NONE = '{dir_up: 1'b0, has_read: 1'b0, has_write: 1'b0, read_bg: 1'b0, write_bg: 1'b0};

endpackage

// File: rtl/march_element_rom.sv
// Combinational lookup: element index -> sweep direction, op mix and data backgrounds.
module march_element_rom
  import march_pkg::*;
(
  input  elem_idx_t i_elem,
  output elem_t     o_entry
);

  always_comb begin
    o_entry = ELEM_NONE;
    case (i_elem)
      3'd0:    o_entry = ELEM_0;
      3'd1:    o_entry = ELEM_1;
      3'd2:    o_entry = ELEM_2;
      3'd3:    o_entry = ELEM_3;
      3'd4:    o_entry = ELEM_4;
      3'd5:    o_entry = ELEM_5;
      default: o_entry = ELEM_NONE;
    endcase
  end

endmodule

// File: rtl/march_bist_controller.sv
// March C- BIST sequencer: steers an external up/down address generator and memory strobes, checks read data.
// Define FAIL_CAPTURE_EN to record address/element of the first miscompare; otherwise those outputs are 0.
module march_bist_controller
  import march_pkg::*;
#(
  parameter int AD_W = 4,
  parameter int DW   = 8
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  output logic            ag_reset,
  output logic            ag_preset,
  output logic            ag_en,
  output logic            ag_up_down,
  input  logic            ag_carry,
  input  logic [AD_W-1:0] ag_address,
  output logic            mem_re,
  output logic            mem_we,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata,
  output logic            busy,
  output logic            done,
  output logic            fail,
  output logic [AD_W-1:0] fail_addr,
  output logic [2:0]      fail_elem
);

  state_t    r_state;
  state_t    w_state_nxt;
  elem_idx_t r_elem;
  elem_idx_t w_elem_nxt;
  elem_t     w_entry;
  logic      r_last;
  logic      r_cmp_vld;
  logic      r_cmp_exp;
  logic      r_fail;
  logic      w_at_last;
  logic      w_last_elem;
  logic      w_start_ok;
  logic      w_miscmp;

  march_element_rom u_rom (
    .i_elem  (r_elem),
    .o_entry (w_entry)
  );

  // carry pulses on the first cycle at the terminal address; r_last covers the second op there
  assign w_at_last   = r_last | ag_carry;
  assign w_last_elem = (r_elem == LAST_ELEM);
  assign w_start_ok  = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_miscmp    = r_cmp_vld && (mem_rdata != {DW{r_cmp_exp}});

  assign busy = (r_state == ST_INIT) || (r_state == ST_OP_R) ||
                (r_state == ST_OP_W) || (r_state == ST_DRAIN);
  assign done = (r_state == ST_DONE);
  assign fail = r_fail;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_elem  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_elem  <= w_elem_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_elem_nxt  = r_elem;
    ag_reset    = 1'b0;
    ag_preset   = 1'b0;
    ag_en       = 1'b0;
    ag_up_down  = 1'b0;
    mem_re      = 1'b0;
    mem_we      = 1'b0;
    mem_wdata   = '0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_state_nxt = ST_INIT;
          w_elem_nxt  = '0;
        end
      end
      ST_INIT: begin
        ag_reset    = w_entry.dir_up;
        ag_preset   = !w_entry.dir_up;
        ag_up_down  = w_entry.dir_up;
        w_state_nxt = w_entry.has_read ? ST_OP_R : ST_OP_W;
      end
      ST_OP_R: begin
        mem_re     = 1'b1;
        ag_up_down = w_entry.dir_up;
        if (w_entry.has_write) begin
          w_state_nxt = ST_OP_W;
        end else if (w_at_last) begin
          w_state_nxt = w_last_elem ? ST_DRAIN : ST_INIT;
          w_elem_nxt  = w_last_elem ? r_elem : elem_idx_t'(r_elem + 3'd1);
        end else begin
          ag_en = 1'b1;
        end
      end
      ST_OP_W: begin
        mem_we     = 1'b1;
        mem_wdata  = {DW{w_entry.write_bg}};
        ag_up_down = w_entry.dir_up;
        if (w_at_last) begin
          w_state_nxt = w_last_elem ? ST_DRAIN : ST_INIT;
          w_elem_nxt  = w_last_elem ? r_elem : elem_idx_t'(r_elem + 3'd1);
        end else begin
          ag_en       = 1'b1;
          w_state_nxt = w_entry.has_read ? ST_OP_R : ST_OP_W;
        end
      end
      ST_DRAIN: w_state_nxt = ST_DONE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last    <= 1'b0;
      r_cmp_vld <= 1'b0;
      r_cmp_exp <= 1'b0;
      r_fail    <= 1'b0;
    end else begin
      r_cmp_vld <= mem_re;
      r_cmp_exp <= w_entry.read_bg;
      if (r_state == ST_INIT) begin
        r_last <= 1'b0;
      end else if (mem_re || mem_we) begin
        r_last <= r_last | ag_carry;
      end
      if (w_start_ok) begin
        r_fail <= 1'b0;
      end else if (w_miscmp) begin
        r_fail <= 1'b1;
      end
    end
  end

`ifdef FAIL_CAPTURE_EN
  logic [AD_W-1:0] r_cmp_addr;
  logic [AD_W-1:0] r_fail_addr;
  elem_idx_t       r_cmp_elem;
  elem_idx_t       r_fail_elem;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cmp_addr  <= '0;
      r_cmp_elem  <= '0;
      r_fail_addr <= '0;
      r_fail_elem <= '0;
    end else begin
      r_cmp_addr <= ag_address;
      r_cmp_elem <= r_elem;
      if (w_start_ok) begin
        r_fail_addr <= '0;
        r_fail_elem <= '0;
      end else if (w_miscmp && !r_fail) begin
        r_fail_addr <= r_cmp_addr;
        r_fail_elem <= r_cmp_elem;
      end
    end
  end

  assign fail_addr = r_fail_addr;
  assign fail_elem = r_fail_elem;
`else
  logic w_unused_addr;
  assign w_unused_addr = ^ag_address;
  assign fail_addr     = '0;
  assign fail_elem     = '0;
`endif

endmodule

// File: tb/tb_march_bist_controller.sv
// Bench for march_bist_controller: generator + faulty-memory models, abstract March C- reference.
module tb_march_bist_controller;

  localparam int AD_W     = 4;
  localparam int DW       = 8;
  localparam int N        = 1 << AD_W;
  localparam int EXP_DONE = 10 * N + 8;
  localparam int MAX_CYC  = 400;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            start = 1'b0;
  logic            ag_reset, ag_preset, ag_en, ag_up_down, ag_carry;
  logic [AD_W-1:0] ag_address;
  logic            mem_re, mem_we;
  logic [DW-1:0]   mem_wdata, mem_rdata;
  logic            busy, done, fail;
  logic [AD_W-1:0] fail_addr;
  logic [2:0]      fail_elem;

  always #5 clk = ~clk;

  march_bist_controller #(.AD_W(AD_W), .DW(DW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .ag_reset   (ag_reset),
    .ag_preset  (ag_preset),
    .ag_en      (ag_en),
    .ag_up_down (ag_up_down),
    .ag_carry   (ag_carry),
    .ag_address (ag_address),
    .mem_re     (mem_re),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .busy       (busy),
    .done       (done),
    .fail       (fail),
    .fail_addr  (fail_addr),
    .fail_elem  (fail_elem)
  );

  // fault configuration: 0 none, 1 stuck-at bit, 2 write to src lands at dst
  int              flt_kind = 0;
  logic [AD_W-1:0] flt_addr = '0, flt_src = '0, flt_dst = '0;
  int              flt_bit = 0;
  logic            flt_sval = 1'b0;

  logic [DW-1:0]   init_arr [N];
  logic [DW-1:0]   mem_arr  [N];
  logic            load_init = 1'b0;

  int total = 0;
  int bad   = 0;
  logic            exp_fail;
  logic [AD_W-1:0] exp_faddr;
  logic [2:0]      exp_felem;

  // March C- as plain data: sweep direction, read/write backgrounds (-1 = no op)
  int el_up [6] = '{1, 1, 1, 0, 0, 1};
  int el_rd [6] = '{-1, 0, 1, 0, 1, 0};
  int el_wr [6] = '{0, 1, 0, 1, 0, -1};

  function automatic logic [AD_W-1:0] f_waddr(input logic [AD_W-1:0] a);
    return (flt_kind == 2 && a == flt_src) ? flt_dst : a;
  endfunction

  function automatic logic [DW-1:0] f_wdata(input logic [AD_W-1:0] a, input logic [DW-1:0] d);
    logic [DW-1:0] m;
    m = DW'(1) << flt_bit;
    if (flt_kind == 1 && a == flt_addr) return flt_sval ? (d | m) : (d & ~m);
    return d;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ag_address <= '0;
      ag_carry   <= 1'b0;
    end else if (ag_reset) begin
      ag_address <= '0;
      ag_carry   <= 1'b0;
    end else if (ag_preset) begin
      ag_address <= '1;
      ag_carry   <= 1'b0;
    end else if (ag_en) begin
      ag_address <= ag_up_down ? ag_address + 1'b1 : ag_address - 1'b1;
      ag_carry   <= ag_up_down ? (ag_address + 1'b1 == '1) : (ag_address - 1'b1 == '0);
    end else begin
      ag_carry <= 1'b0;
    end
  end

  always @(posedge clk) begin
    if (load_init) begin
      mem_arr <= init_arr;
    end else begin
      if (mem_we) mem_arr[f_waddr(ag_address)] <= f_wdata(f_waddr(ag_address), mem_wdata);
      if (mem_re) mem_rdata <= mem_arr[ag_address];
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Walk the algorithm element by element over the same faulty storage.
  task automatic ref_model();
    logic [DW-1:0] m [N];
    logic [DW-1:0] bgv;
    int a;
    m = init_arr;
    exp_fail  = 1'b0;
    exp_faddr = '0;
    exp_felem = '0;
    for (int e = 0; e < 6; e++) begin
      for (int i = 0; i < N; i++) begin
        a = (el_up[e] != 0) ? i : N - 1 - i;
        if (el_rd[e] >= 0) begin
          bgv = (el_rd[e] == 1) ? '1 : '0;
          if (m[a] !== bgv && !exp_fail) begin
            exp_fail  = 1'b1;
            exp_faddr = AD_W'(a);
            exp_felem = 3'(e);
          end
        end
        if (el_wr[e] >= 0) begin
          bgv = (el_wr[e] == 1) ? '1 : '0;
          m[f_waddr(AD_W'(a))] = f_wdata(f_waddr(AD_W'(a)), bgv);
        end
      end
    end
  endtask

  task automatic load_random_mem();
    for (int i = 0; i < N; i++) init_arr[i] = DW'($urandom);
    @(negedge clk) load_init = 1'b1;
    @(negedge clk) load_init = 1'b0;
  endtask

  task automatic run_test(input string tag, input int restart_at);
    int cyc, n_busy, n_re, n_we, n_rst, n_pre, n_en, n_both, n_wbad;
    load_random_mem();
    ref_model();
    n_busy = 0; n_re = 0; n_we = 0; n_rst = 0; n_pre = 0; n_en = 0; n_both = 0; n_wbad = 0;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 1;
    check({tag, "_done_low"}, done, 1'b0);
    check({tag, "_busy_high"}, busy, 1'b1);
    while (!done && cyc < MAX_CYC) begin
      if (busy) n_busy++;
      if (mem_re) n_re++;
      if (mem_we) n_we++;
      if (ag_reset) n_rst++;
      if (ag_preset) n_pre++;
      if (ag_en) n_en++;
      if (mem_re && mem_we) n_both++;
      if (mem_we && mem_wdata != '0 && mem_wdata != '1) n_wbad++;
      start = (cyc == restart_at);
      @(posedge clk);
      #1 cyc++;
    end
    start = 1'b0;
    check({tag, "_done_cycle"}, cyc, EXP_DONE);
    check({tag, "_busy_cycles"}, n_busy, EXP_DONE - 1);
    check({tag, "_busy_at_done"}, busy, 1'b0);
    check({tag, "_reads"}, n_re, 5 * N);
    check({tag, "_writes"}, n_we, 5 * N);
    check({tag, "_ag_resets"}, n_rst, 4);
    check({tag, "_ag_presets"}, n_pre, 2);
    check({tag, "_ag_en"}, n_en, 6 * (N - 1));
    check({tag, "_re_we_overlap"}, n_both, 0);
    check({tag, "_wdata_bg"}, n_wbad, 0);
    check({tag, "_fail"}, fail, exp_fail);
`ifdef FAIL_CAPTURE_EN
    check({tag, "_fail_addr"}, fail_addr, exp_faddr);
    check({tag, "_fail_elem"}, fail_elem, exp_felem);
`else
    check({tag, "_fail_addr"}, fail_addr, '0);
    check({tag, "_fail_elem"}, fail_elem, '0);
`endif
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs",
          {ag_reset, ag_preset, ag_en, ag_up_down, mem_re, mem_we, mem_wdata,
           busy, done, fail, fail_addr, fail_elem}, '0);
    @(negedge clk) reset_n = 1'b1;

    flt_kind = 0;
    run_test("clean", 0);

    flt_kind = 1; flt_addr = 4'd5; flt_bit = 0; flt_sval = 1'b0;
    run_test("sa0_a5", 0);
    check("sa0_a5_fail_set", fail, 1'b1);
`ifdef FAIL_CAPTURE_EN
    check("sa0_a5_elem2", fail_elem, 3'd2);
    check("sa0_a5_addr5", fail_addr, 4'd5);
`endif

    flt_kind = 2; flt_src = 4'd9; flt_dst = 4'd3;
    run_test("alias_9_3", 0);

    flt_kind = 0;
    run_test("restart_ignored", 40);

    for (int k = 0; k < 5; k++) begin
      flt_kind = $urandom_range(0, 2);
      flt_addr = AD_W'($urandom);
      flt_bit  = $urandom_range(0, DW - 1);
      flt_sval = 1'($urandom);
      flt_src  = AD_W'($urandom);
      flt_dst  = flt_src ^ AD_W'($urandom_range(1, N - 1));
      run_test($sformatf("rand%0d_k%0d", k, flt_kind), 0);
    end

    // abort mid-test with a fault already flagged, then a clean rerun
    flt_kind = 1; flt_addr = 4'd2; flt_bit = 0; flt_sval = 1'b1;
    load_random_mem();
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (59) @(posedge clk);
    #1 check("abort_fail_before", fail, 1'b1);
    check("abort_busy_before", busy, 1'b1);
    #2 reset_n = 1'b0;
    #1 check("abort_outputs",
             {ag_reset, ag_preset, ag_en, ag_up_down, mem_re, mem_we, mem_wdata,
              busy, done, fail, fail_addr, fail_elem}, '0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    flt_kind = 0;
    run_test("after_abort", 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
